bitty_control: RTL

- Multi-cycle control unit for the BittyPro datapath; sits directly upstream of the 16-bit ALU.
- Accepts one 16-bit instruction per valid/ready handshake and sequences the datapath through operand loads, ALU execution and writeback.
- Drives the register file enables, the bus mux select, the ALU select code and the immediate value.

---
 rtl/bitty_pkg.sv | 25 ++
 rtl/bitty_if.sv | 23 ++
 rtl/bitty_decoder.sv | 22 ++
 rtl/bitty_control.sv | 70 +++++++
 4 files changed

// File: rtl/bitty_pkg.sv
// bitty_pkg: shared encodings for the BittyPro control unit and datapath
package bitty_pkg;
   localparam int DATA_W   = 16;
   localparam int IMM_W    = 8;
   localparam int NUM_REGS = 8;
   localparam int REG_W    = $clog2(NUM_REGS);
   localparam int RX_LSB   = 13;
   localparam int RY_LSB   = 10;
   localparam int IMM_LSB  = 5;
   localparam int ALU_LSB  = 2;
   localparam int FMT_LSB  = 0;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD_S = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;
   localparam logic [1:0] FMT_REG = 2'b00;
   localparam logic [1:0] FMT_IMM = 2'b01;
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SHL = 3'd5;
   localparam logic [2:0] ALU_SHR = 3'd6;
   localparam logic [2:0] ALU_CMP = 3'd7;
   localparam logic [3:0] MUX_C   = 4'd8;
   localparam logic [3:0] MUX_IMM = 4'd9;
endpackage

// File: rtl/bitty_if.sv
// bitty_if: instruction handshake plus datapath control bundle
interface bitty_if;
   import bitty_pkg::*;
   logic                instr_valid;
   logic [DATA_W-1:0]   instr;
   logic                instr_ready;
   logic [3:0]          mux_sel;
   logic                en_s;
   logic                en_c;
   logic [NUM_REGS-1:0] en_i;
   logic [2:0]          alu_sel;
   logic [DATA_W-1:0]   imm_out;
   logic                done;
   logic                illegal;
   modport master (
      output instr_valid, instr,
      input  instr_ready, mux_sel, en_s, en_c, en_i, alu_sel, imm_out, done, illegal
   );
   modport slave (
      input  instr_valid, instr,
      output instr_ready, mux_sel, en_s, en_c, en_i, alu_sel, imm_out, done, illegal
   );
endinterface

// File: rtl/bitty_decoder.sv
// bitty_decoder: splits the captured instruction into its fields
module bitty_decoder
   import bitty_pkg::*;
(
   input  logic [DATA_W-1:0]   i_instr,
   output logic [REG_W-1:0]    o_rx,
   output logic [REG_W-1:0]    o_ry,
   output logic [1:0]          o_fmt,
   output logic [2:0]          o_alu_sel,
   output logic [DATA_W-1:0]   o_imm,
   output logic [NUM_REGS-1:0] o_rx_onehot,
   output logic                o_illegal
);
   assign o_rx        = i_instr[RX_LSB +: REG_W];
   assign o_ry        = i_instr[RY_LSB +: REG_W];
   assign o_fmt       = i_instr[FMT_LSB +: 2];
   assign o_alu_sel   = i_instr[ALU_LSB +: 3];
   assign o_imm       = {{(DATA_W-IMM_W){1'b0}}, i_instr[IMM_LSB +: IMM_W]};
   assign o_rx_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << o_rx;
   // fmt 10 and 11 are reserved
   assign o_illegal   = o_fmt[1];
endmodule

// File: rtl/bitty_control.sv
// bitty_control: multi-cycle sequencer driving the BittyPro datapath
module bitty_control
   import bitty_pkg::*;
(
   input logic     clk,
   input logic     reset,
   bitty_if.slave  bus
);
   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_instr;
   logic                w_accept;
   logic [REG_W-1:0]    w_rx;
   logic [REG_W-1:0]    w_ry;
   logic [1:0]          w_fmt;
   logic [2:0]          w_alu;
   logic [DATA_W-1:0]   w_imm;
   logic [NUM_REGS-1:0] w_rx_oh;
   logic                w_illegal;

   assign w_accept = (r_state == IDLE) && bus.instr_valid;

   bitty_decoder u_dec (
      .i_instr     (r_instr),
      .o_rx        (w_rx),
      .o_ry        (w_ry),
      .o_fmt       (w_fmt),
      .o_alu_sel   (w_alu),
      .o_imm       (w_imm),
      .o_rx_onehot (w_rx_oh),
      .o_illegal   (w_illegal)
   );

   // state register and instruction capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_instr <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) r_instr <= bus.instr;
      end
   end

   // next state: reserved formats skip straight to writeback
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_accept ? (bus.instr[FMT_LSB+1] ? WB : LOAD_S) : IDLE;
         LOAD_S:  w_next = EXEC;
         EXEC:    w_next = WB;
         default: w_next = IDLE;
      endcase
   end

   // outputs decoded only from state and the captured instruction
   always_comb begin
      bus.instr_ready = (r_state == IDLE);
      bus.en_s        = (r_state == LOAD_S);
      bus.en_c        = (r_state == EXEC);
      bus.en_i        = (r_state == WB && !w_illegal) ? w_rx_oh : '0;
      bus.alu_sel     = (r_state == EXEC) ? w_alu : '0;
      bus.mux_sel     = (r_state == LOAD_S) ? {1'b0, w_rx} :
                        (r_state == EXEC) ? ((w_fmt == FMT_IMM) ? MUX_IMM : {1'b0, w_ry}) :
                        (r_state == WB && !w_illegal) ? MUX_C : 4'd0;
      bus.imm_out     = w_imm;
      bus.done        = (r_state == WB);
      bus.illegal     = (r_state == WB) && w_illegal;
   end
endmodule
